// File: rtl/dig_seq_ctrl_pkg.sv
// Shared definitions for the digital-core power-up / soft-reset sequencer:
// state encoding, default guard intervals and the per-state output decode.
package dig_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_RST_ASSERT = 3'd1,
    ST_RST_REL    = 3'd2,
    ST_RUN        = 3'd3,
    ST_GATE_OFF   = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_RST_HOLD_CYC = 16;
  localparam int unsigned DEF_EN_DELAY_CYC = 8;

  typedef struct packed {
    logic rstn;
    logic clk_en;
    logic busy;
    logic running;
  } seq_out_t;

  // Output levels are a pure function of state so they can be registered from state_d.
  function automatic seq_out_t state_outputs(input seq_state_e st);
    seq_out_t o;
    o = '0;
    case (st)
      ST_RST_ASSERT: o = '{rstn: 1'b0, clk_en: 1'b0, busy: 1'b1, running: 1'b0};
      ST_RST_REL:    o = '{rstn: 1'b1, clk_en: 1'b0, busy: 1'b1, running: 1'b0};
      ST_RUN:        o = '{rstn: 1'b1, clk_en: 1'b1, busy: 1'b0, running: 1'b1};
      ST_GATE_OFF:   o = '{rstn: 1'b1, clk_en: 1'b0, busy: 1'b1, running: 1'b0};
      default:       o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dig_seq_ctrl.sv
// Orders soft-reset release before clock ungating (and gating before reset
// assertion) with programmable guard intervals; all outputs are flops.
module dig_seq_ctrl
  import dig_seq_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC = DEF_RST_HOLD_CYC,
  parameter int unsigned EN_DELAY_CYC = DEF_EN_DELAY_CYC,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_req,
  input  logic stop_req,
  input  logic soft_rst_req,
  input  logic err_clr,
  output logic digrf_rstn,
  output logic enable_digclk,
  output logic busy,
  output logic running,
  output logic seq_err
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD   = CNT_W'(EN_DELAY_CYC - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             then_rst_q, then_rst_d;
  logic             seq_err_q, seq_err_d;
  seq_out_t         out_q;
  logic             any_req;
  logic             err_evt;

  assign any_req = start_req | stop_req | soft_rst_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    then_rst_d = then_rst_q;
    err_evt    = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (start_req) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = HOLD_LD;
        end
      end
      ST_RST_ASSERT: begin
        err_evt = any_req;
        if (cnt_q == '0) begin
          state_d = ST_RST_REL;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RST_REL: begin
        err_evt = any_req;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        // stop beats soft reset; start is a no-op here
        if (stop_req) begin
          state_d    = ST_GATE_OFF;
          cnt_d      = EN_LD;
          then_rst_d = 1'b0;
        end else if (soft_rst_req) begin
          state_d    = ST_GATE_OFF;
          cnt_d      = EN_LD;
          then_rst_d = 1'b1;
        end
      end
      ST_GATE_OFF: begin
        err_evt = any_req;
        if (cnt_q == '0) begin
          state_d    = then_rst_q ? ST_RST_ASSERT : ST_OFF;
          cnt_d      = then_rst_q ? HOLD_LD : '0;
          then_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_OFF;
        cnt_d      = '0;
        then_rst_d = 1'b0;
      end
    endcase
    seq_err_d = err_evt | (seq_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      then_rst_q <= 1'b0;
      seq_err_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      then_rst_q <= then_rst_d;
      seq_err_q  <= seq_err_d;
      out_q      <= state_outputs(state_d);
    end
  end

  assign digrf_rstn    = out_q.rstn;
  assign enable_digclk = out_q.clk_en;
  assign busy          = out_q.busy;
  assign running       = out_q.running;
  assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_dig_seq_ctrl.sv
// Directed bench for dig_seq_ctrl (RST_HOLD_CYC=4, EN_DELAY_CYC=3) plus a
// random-pulse soak watched by an ordering monitor.
module tb_dig_seq_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic start_req, stop_req, soft_rst_req, err_clr;
  logic digrf_rstn, enable_digclk, busy, running, seq_err;

  int n_checks = 0;
  int n_errors = 0;

  bit   mon_en = 1'b0;
  bit   prev_valid = 1'b0;
  logic prev_r, prev_e;

  always #5 clk = ~clk;

  dig_seq_ctrl #(
    .RST_HOLD_CYC(4),
    .EN_DELAY_CYC(3),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_req    (start_req),
    .stop_req     (stop_req),
    .soft_rst_req (soft_rst_req),
    .err_clr      (err_clr),
    .digrf_rstn   (digrf_rstn),
    .enable_digclk(enable_digclk),
    .busy         (busy),
    .running      (running),
    .seq_err      (seq_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic r, input logic c);
    start_req    = s;
    stop_req     = p;
    soft_rst_req = r;
    err_clr      = c;
    tick();
    start_req    = 1'b0;
    stop_req     = 1'b0;
    soft_rst_req = 1'b0;
    err_clr      = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic r, input logic e,
                            input logic b, input logic run);
    check({tag, ".rstn"},    {31'b0, digrf_rstn},    {31'b0, r});
    check({tag, ".en"},      {31'b0, enable_digclk}, {31'b0, e});
    check({tag, ".busy"},    {31'b0, busy},          {31'b0, b});
    check({tag, ".running"}, {31'b0, running},       {31'b0, run});
  endtask

  // Clock enable must imply reset released; the two never move on one edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_en_imp_rstn", {31'b0, enable_digclk & ~digrf_rstn}, 32'd0);
      if (prev_valid)
        check("inv_same_edge",
              {31'b0, (digrf_rstn != prev_r) && (enable_digclk != prev_e)}, 32'd0);
      prev_r     = digrf_rstn;
      prev_e     = enable_digclk;
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    rstn = 1'b0;
    start_req = 1'b0; stop_req = 1'b0; soft_rst_req = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.seq_err", {31'b0, seq_err}, 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;
    repeat (2) tick();

    // Reset mid-RST_REL
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    expect_out("pre_rst_rel", 1'b1, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out($sformatf("post_rst[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Power-up sequence
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      expect_out($sformatf("start[%0d]", i), i >= 4, i >= 7, i < 7, i >= 7);
    end

    // Soft reset from RUN
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      expect_out($sformatf("soft[%0d]", i), !(i >= 3 && i < 7), i >= 10, i < 10, i >= 10);
    end
    check("soft.seq_err", {31'b0, seq_err}, 32'd0);

    // Stop and soft reset together: stop wins
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      expect_out($sformatf("stop_soft[%0d]", i), i < 3, 1'b0, i < 3, 1'b0);
    end

    // Request while busy sets seq_err, timing unchanged
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("err_busy.seq_err", {31'b0, seq_err}, 32'd1);
    for (int i = 1; i < 10; i++) begin
      if (i > 1) tick();
      expect_out($sformatf("err_start[%0d]", i), i >= 4, i >= 7, i < 7, i >= 7);
    end
    check("err_sticky", {31'b0, seq_err}, 32'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("err_clr", {31'b0, seq_err}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_in_run.seq_err", {31'b0, seq_err}, 32'd0);
    expect_out("start_in_run", 1'b1, 1'b1, 1'b0, 1'b1);

    // err_clr coincident with a new error keeps the flag set
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    check("err_clr_vs_err", {31'b0, seq_err}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      if (i > 1) tick();
      expect_out($sformatf("stop_err[%0d]", i), i < 3, 1'b0, i < 3, 1'b0);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("err_clr2", {31'b0, seq_err}, 32'd0);

    // stop/soft in OFF are silent no-ops
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("noop_off.seq_err", {31'b0, seq_err}, 32'd0);
    tick();
    expect_out("noop_off", 1'b0, 1'b0, 1'b0, 1'b0);

    // Random legal pulses; the monitor checks ordering each cycle
    for (int c = 0; c < 10000; c++) begin
      start_req    = ($urandom_range(0, 15) == 0);
      stop_req     = ($urandom_range(0, 31) == 0);
      soft_rst_req = ($urandom_range(0, 23) == 0);
      err_clr      = ($urandom_range(0, 7) == 0);
      tick();
    end
    start_req = 1'b0; stop_req = 1'b0; soft_rst_req = 1'b0; err_clr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
